frame_header_decoder: RTL

FRAME_HEADER_DECODER -- requirements
Module: frame_header_decoder

---
 rtl/frame_header_decoder_pkg.sv | 90 +++++++++
 rtl/frame_header_decoder_crc8.sv | 26 ++
 rtl/frame_header_decoder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_header_decoder_pkg.sv
// Shared definitions for the frame header decoder: FSM encoding, sync words,
// CRC-8 polynomial and the block-size / extension decode helpers.
package frame_header_decoder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_SYNC   = 4'd2,
        ST_HDR    = 4'd3,
        ST_UTF8   = 4'd4,
        ST_EXT_BS = 4'd5,
        ST_EXT_SR = 4'd6,
        ST_CRC    = 4'd7,
        ST_DONE   = 4'd8,
        ST_ERR    = 4'd9
    } fhd_state_e;

    localparam logic [15:0] SYNC_FIXED      = 16'hFFF8;
    localparam logic [15:0] SYNC_VARIABLE   = 16'hFFF9;
    localparam logic [7:0]  CRC8_POLY       = 8'h07;

    localparam logic [15:0] BS_192          = 16'd192;
    localparam logic [15:0] BS_576          = 16'd576;
    localparam logic [15:0] BS_256          = 16'd256;
    localparam logic [15:0] BS_EXT_OVERFLOW = 16'hFFFF;
    localparam logic [3:0]  BS_CODE_EXT8    = 4'b0110;
    localparam logic [3:0]  BS_CODE_EXT16   = 4'b0111;

    localparam logic [3:0]  SR_CODE_EXT8    = 4'b1100;
    localparam logic [3:0]  SR_CODE_EXT16A  = 4'b1101;
    localparam logic [3:0]  SR_CODE_EXT16B  = 4'b1110;
    localparam logic [3:0]  SR_CODE_INVALID = 4'b1111;
    localparam logic [3:0]  CH_CODE_FIRST_RSVD = 4'b1011;

    // Fixed block sizes; extension codes and the reserved code decode to zero here.
    function automatic logic [15:0] bs_lookup(input logic [3:0] code);
        logic [15:0] v;
        case (code)
            4'b0001:                            v = BS_192;
            4'b0010, 4'b0011, 4'b0100, 4'b0101: v = BS_576 << (code - 4'd2);
            4'b1000, 4'b1001, 4'b1010, 4'b1011,
            4'b1100, 4'b1101, 4'b1110, 4'b1111: v = BS_256 << (code - 4'd8);
            default:                            v = 16'd0;
        endcase
        return v;
    endfunction

    function automatic logic hdr_invalid(input logic [7:0] b2, input logic [7:0] b3);
        return (b2[7:4] == 4'b0000) || (b2[3:0] == SR_CODE_INVALID) ||
               (b3[7:4] >= CH_CODE_FIRST_RSVD) || (b3[3:1] == 3'b011) ||
               (b3[3:1] == 3'b111) || (b3[0] == 1'b1);
    endfunction

    // Returns {bad_lead, continuation_byte_count}.
    function automatic logic [3:0] utf8_extra(input logic [7:0] lead);
        logic [3:0] r;
        casez (lead)
            8'b0???????: r = {1'b0, 3'd0};
            8'b110?????: r = {1'b0, 3'd1};
            8'b1110????: r = {1'b0, 3'd2};
            8'b11110???: r = {1'b0, 3'd3};
            8'b111110??: r = {1'b0, 3'd4};
            8'b1111110?: r = {1'b0, 3'd5};
            8'b11111110: r = {1'b0, 3'd6};
            default:     r = {1'b1, 3'd0};
        endcase
        return r;
    endfunction

    function automatic logic [2:0] bs_ext_len(input logic [3:0] code);
        logic [2:0] n;
        case (code)
            BS_CODE_EXT8:  n = 3'd1;
            BS_CODE_EXT16: n = 3'd2;
            default:       n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] sr_ext_len(input logic [3:0] code);
        logic [2:0] n;
        case (code)
            SR_CODE_EXT8:                   n = 3'd1;
            SR_CODE_EXT16A, SR_CODE_EXT16B: n = 3'd2;
            default:                        n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/frame_header_decoder_crc8.sv
// Combinational CRC-8 (poly 0x07, MSB first) update of one byte; shared with
// other frame CRC checkers.
module crc8_byte
    import frame_header_decoder_pkg::*;
(
    input  logic [7:0] i_data,
    input  logic [7:0] i_crc,
    output logic [7:0] o_crc
);

    logic [7:0] w_c;

    // Eight shift/xor steps over the byte folded into the running CRC.
    always_comb begin
        w_c = i_crc ^ i_data;
        for (int i = 0; i < 8; i++) begin
            if (w_c[7]) begin
                w_c = {w_c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                w_c = {w_c[6:0], 1'b0};
            end
        end
        o_crc = w_c;
    end

endmodule

// File: rtl/frame_header_decoder.sv
// Frame header decoder: walks the header byte stream out of a word RAM,
// validates sync, codes, UTF-8 frame number and CRC-8, then latches fields.
module frame_header_decoder
    import frame_header_decoder_pkg::*;
(
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iEnable,
    input  logic [15:0] iStartAddr,
    input  logic [15:0] iData,
    output logic [15:0] oReadAddr,
    output logic        oHeaderValid,
    output logic        oHeaderError,
    output logic [15:0] oBlockSize,
    output logic [3:0]  oChannelAssign,
    output logic [2:0]  oSampleSize,
    output logic [15:0] oSubframeAddr,
    output logic        oSubframeByteOffset
);

    fhd_state_e  r_state;
    logic [15:0] r_addr;
    logic [15:0] r_word;
    logic        r_word_valid;
    logic        r_wait;
    logic        r_lo;
    logic [2:0]  r_cnt;
    logic        r_lead;
    logic [7:0]  r_tmp;
    logic [7:0]  r_crc;
    logic [3:0]  r_bs_code;
    logic [3:0]  r_sr_code;
    logic [3:0]  r_ch_code;
    logic [2:0]  r_ss_code;
    logic [15:0] r_ext;
    logic [15:0] r_bs;
    logic [15:0] r_sub_addr;
    logic        r_sub_off;
    logic        r_header_valid;
    logic        r_header_error;
    logic [15:0] r_out_block_size;
    logic [3:0]  r_out_chan;
    logic [2:0]  r_out_ssize;
    logic [15:0] r_out_sub_addr;
    logic        r_out_sub_off;

    logic [7:0]  w_byte;
    logic [7:0]  w_crc_next;
    logic        w_parsing;
    logic        w_take;
    logic [15:0] w_ext_next;
    logic [3:0]  w_utf_info;
    logic [2:0]  w_bs_len;
    logic [2:0]  w_sr_len;
    fhd_state_e  w_route_utf;
    logic [2:0]  w_route_utf_cnt;
    fhd_state_e  w_route_bs;
    logic [2:0]  w_route_bs_cnt;

    crc8_byte u_crc8 (
        .i_data (w_byte),
        .i_crc  (r_crc),
        .o_crc  (w_crc_next)
    );

    // Current byte, consume strobe and the routing after UTF-8 / block-size extension.
    always_comb begin
        w_byte     = r_lo ? r_word[7:0] : r_word[15:8];
        w_parsing  = r_state inside {ST_FETCH, ST_SYNC, ST_HDR, ST_UTF8, ST_EXT_BS, ST_EXT_SR, ST_CRC};
        w_take     = r_word_valid && (r_state inside {ST_SYNC, ST_HDR, ST_UTF8, ST_EXT_BS, ST_EXT_SR, ST_CRC});
        w_ext_next = {r_ext[7:0], w_byte};
        w_utf_info = utf8_extra(w_byte);
        w_bs_len   = bs_ext_len(r_bs_code);
        w_sr_len   = sr_ext_len(r_sr_code);
        if (w_sr_len != 3'd0) begin
            w_route_bs     = ST_EXT_SR;
            w_route_bs_cnt = w_sr_len;
        end else begin
            w_route_bs     = ST_CRC;
            w_route_bs_cnt = 3'd0;
        end
        if (w_bs_len != 3'd0) begin
            w_route_utf     = ST_EXT_BS;
            w_route_utf_cnt = w_bs_len;
        end else begin
            w_route_utf     = w_route_bs;
            w_route_utf_cnt = w_route_bs_cnt;
        end
    end

    // Header parse FSM with word fetcher; everything freezes while iEnable is low.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state          <= ST_IDLE;
            r_addr           <= 16'd0;
            r_word           <= 16'd0;
            r_word_valid     <= 1'b0;
            r_wait           <= 1'b0;
            r_lo             <= 1'b0;
            r_cnt            <= 3'd0;
            r_lead           <= 1'b0;
            r_tmp            <= 8'd0;
            r_crc            <= 8'd0;
            r_bs_code        <= 4'd0;
            r_sr_code        <= 4'd0;
            r_ch_code        <= 4'd0;
            r_ss_code        <= 3'd0;
            r_ext            <= 16'd0;
            r_bs             <= 16'd0;
            r_sub_addr       <= 16'd0;
            r_sub_off        <= 1'b0;
            r_header_valid   <= 1'b0;
            r_header_error   <= 1'b0;
            r_out_block_size <= 16'd0;
            r_out_chan       <= 4'd0;
            r_out_ssize      <= 3'd0;
            r_out_sub_addr   <= 16'd0;
            r_out_sub_off    <= 1'b0;
        end else begin
            r_header_valid <= 1'b0;
            r_header_error <= 1'b0;
            if (iEnable) begin
                // RAM answers one cycle after the address: skip one edge, then capture.
                if (w_parsing && !r_word_valid) begin
                    if (r_wait) begin
                        r_wait <= 1'b0;
                    end else begin
                        r_word       <= iData;
                        r_word_valid <= 1'b1;
                    end
                end
                if (w_take) begin
                    if (r_lo) begin
                        r_lo         <= 1'b0;
                        r_word_valid <= 1'b0;
                        r_wait       <= 1'b1;
                        r_addr       <= r_addr + 16'd1;
                    end else begin
                        r_lo <= 1'b1;
                    end
                    if (r_state != ST_CRC) begin
                        r_crc <= w_crc_next;
                    end
                end
                case (r_state)
                    ST_IDLE: begin
                        r_addr       <= iStartAddr;
                        r_word_valid <= 1'b0;
                        r_wait       <= 1'b1;
                        r_lo         <= 1'b0;
                        r_crc        <= 8'd0;
                        r_cnt        <= 3'd0;
                        r_state      <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        if (r_word_valid) begin
                            r_state <= ST_SYNC;
                        end
                    end
                    ST_SYNC: begin
                        if (w_take) begin
                            if (r_cnt == 3'd0) begin
                                r_tmp <= w_byte;
                                r_cnt <= 3'd1;
                            end else if (({r_tmp, w_byte} == SYNC_FIXED) ||
                                         ({r_tmp, w_byte} == SYNC_VARIABLE)) begin
                                r_cnt   <= 3'd0;
                                r_state <= ST_HDR;
                            end else begin
                                r_state <= ST_ERR;
                            end
                        end
                    end
                    ST_HDR: begin
                        if (w_take) begin
                            if (r_cnt == 3'd0) begin
                                r_bs_code <= w_byte[7:4];
                                r_sr_code <= w_byte[3:0];
                                r_cnt     <= 3'd1;
                            end else begin
                                r_ch_code <= w_byte[7:4];
                                r_ss_code <= w_byte[3:1];
                                r_bs      <= bs_lookup(r_bs_code);
                                r_lead    <= 1'b1;
                                if (hdr_invalid({r_bs_code, r_sr_code}, w_byte)) begin
                                    r_state <= ST_ERR;
                                end else begin
                                    r_state <= ST_UTF8;
                                end
                            end
                        end
                    end
                    ST_UTF8: begin
                        if (w_take) begin
                            if (r_lead && w_utf_info[3]) begin
                                r_state <= ST_ERR;
                            end else if (!r_lead && (w_byte[7:6] != 2'b10)) begin
                                r_state <= ST_ERR;
                            end else if ((r_lead && (w_utf_info[2:0] == 3'd0)) ||
                                         (!r_lead && (r_cnt == 3'd1))) begin
                                r_state <= w_route_utf;
                                r_cnt   <= w_route_utf_cnt;
                                r_ext   <= 16'd0;
                            end else if (r_lead) begin
                                r_lead <= 1'b0;
                                r_cnt  <= w_utf_info[2:0];
                            end else begin
                                r_cnt <= r_cnt - 3'd1;
                            end
                        end
                    end
                    ST_EXT_BS: begin
                        if (w_take) begin
                            if (r_cnt != 3'd1) begin
                                r_ext <= w_ext_next;
                                r_cnt <= r_cnt - 3'd1;
                            end else if (w_ext_next == BS_EXT_OVERFLOW) begin
                                r_bs    <= BS_EXT_OVERFLOW;
                                r_state <= ST_ERR;
                            end else begin
                                r_bs    <= w_ext_next + 16'd1;
                                r_state <= w_route_bs;
                                r_cnt   <= w_route_bs_cnt;
                            end
                        end
                    end
                    ST_EXT_SR: begin
                        if (w_take) begin
                            if (r_cnt == 3'd1) begin
                                r_state <= ST_CRC;
                            end else begin
                                r_cnt <= r_cnt - 3'd1;
                            end
                        end
                    end
                    ST_CRC: begin
                        if (w_take) begin
                            // The byte after the CRC shares this word when the CRC is the high byte.
                            r_sub_addr <= r_lo ? (r_addr + 16'd1) : r_addr;
                            r_sub_off  <= ~r_lo;
                            if (w_byte == r_crc) begin
                                r_state <= ST_DONE;
                            end else begin
                                r_state <= ST_ERR;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_out_block_size <= r_bs;
                        r_out_chan       <= r_ch_code;
                        r_out_ssize      <= r_ss_code;
                        r_out_sub_addr   <= r_sub_addr;
                        r_out_sub_off    <= r_sub_off;
                        r_header_valid   <= 1'b1;
                        r_state          <= ST_IDLE;
                    end
                    ST_ERR: begin
                        r_header_error <= 1'b1;
                        r_state        <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign oReadAddr           = r_addr;
    assign oHeaderValid        = r_header_valid;
    assign oHeaderError        = r_header_error;
    assign oBlockSize          = r_out_block_size;
    assign oChannelAssign      = r_out_chan;
    assign oSampleSize         = r_out_ssize;
    assign oSubframeAddr       = r_out_sub_addr;
    assign oSubframeByteOffset = r_out_sub_off;

endmodule
